// File: rtl/serial_adder_pkg.sv
// Shared types and elaboration helpers for the digit-serial adder/subtractor.
// Holds the FSM state encoding and the digit-count / counter-width functions.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int calc_ndig(input int width, input int digit);
    return width / digit;
  endfunction

  // Counter must hold 0..NDIG-1; a one-digit configuration still gets one bit.
  function automatic int calc_cnt_w(input int width, input int digit);
    int n;
    n = width / digit;
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/serial_adder_digit_adder.sv
// DIGIT-bit ripple adder built from one-bit full adders.
// Also exposes the carry into the top bit so the caller can form signed overflow.
module digit_adder #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  input  logic             ci,
  output logic [DIGIT-1:0] s,
  output logic             co,
  output logic             c_top
);

  logic [DIGIT:0] c;

  assign c[0] = ci;

  for (genvar i = 0; i < DIGIT; i++) begin : g_fa
    assign s[i]   = x[i] ^ y[i] ^ c[i];
    assign c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
  end

  assign co    = c[DIGIT];
  assign c_top = c[DIGIT-1];

endmodule

// File: rtl/serial_adder.sv
// Digit-serial adder/subtractor: resolves WIDTH bits DIGIT at a time through a
// registered carry, with valid/ready handshakes on operand and result sides.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output state_t           state_dbg
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high. Producers hold valid (and data) until that edge; ready never
  // depends combinationally on valid, and out_valid/results hold until taken.

  localparam int NDIG = calc_ndig(WIDTH, DIGIT);
  localparam int CW   = calc_cnt_w(WIDTH, DIGIT);

  if ((DIGIT < 1) || (WIDTH % DIGIT != 0)) begin : g_bad_digit
    $error("serial_adder: WIDTH must be a positive multiple of DIGIT");
  end

  state_t state_q, state_d;

  logic [WIDTH-1:0] a_q, b_q, res_q, res_next;
  logic             carry_q;
  logic [CW-1:0]    cnt_q;

  logic [DIGIT-1:0] dsum;
  logic             dco, dtop;
  logic             accept, last_dig;

  assign in_ready  = (state_q == IDLE);
  assign accept    = in_valid && in_ready;
  assign last_dig  = (state_q == RUN) && (cnt_q == CW'(NDIG - 1));
  assign state_dbg = state_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = RUN;
      RUN:     if (last_dig) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  digit_adder #(.DIGIT(DIGIT)) u_digit (
    .x     (a_q[DIGIT-1:0]),
    .y     (b_q[DIGIT-1:0]),
    .ci    (carry_q),
    .s     (dsum),
    .co    (dco),
    .c_top (dtop)
  );

  // Digit results enter at the MSB end so after NDIG shifts the LSB digit lands at bit 0.
  assign res_next = (res_q >> DIGIT) | (WIDTH'(dsum) << (WIDTH - DIGIT));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q       <= '0;
      b_q       <= '0;
      res_q     <= '0;
      carry_q   <= 1'b0;
      cnt_q     <= '0;
      sum       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      if (accept) begin
        a_q     <= a;
        b_q     <= sub ? ~b : b;
        carry_q <= sub ? 1'b1 : cin;
        cnt_q   <= '0;
      end else if (state_q == RUN) begin
        a_q     <= a_q >> DIGIT;
        b_q     <= b_q >> DIGIT;
        res_q   <= res_next;
        carry_q <= dco;
        cnt_q   <= cnt_q + CW'(1);
        if (last_dig) begin
          sum       <= res_next;
          cout      <= dco;
          ovf       <= dco ^ dtop;
          out_valid <= 1'b1;
        end
      end
      if ((state_q == DONE) && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: directed cases on (8,4), (32,1), (32,4) and a
// randomized stalled-handshake regression on (8,1), (8,8), (32,4), (16,2).
module tb_serial_adder;
  import serial_adder_pkg::*;

  localparam int NTX    = 2000;
  localparam int BUDGET = 40000;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;
  int rnd_done_cnt = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    else n_pass++;
  endtask

  // Reference: plain wide arithmetic on the operand actually added; {ovf, cout, sum}.
  function automatic logic [33:0] ref_model(input int w, input logic [31:0] a, input logic [31:0] b,
                                            input logic ci, input logic sb);
    logic [63:0] m, bb, t;
    logic        co, ov;
    m  = (64'd1 << w) - 64'd1;
    bb = sb ? (~{32'd0, b}) & m : {32'd0, b} & m;
    t  = ({32'd0, a} & m) + bb + (sb ? 64'd1 : {63'd0, ci});
    co = t[w];
    ov = (a[w-1] == bb[w-1]) && (t[w-1] != a[w-1]);
    t  = t & m;
    return {ov, co, t[31:0]};
  endfunction

  function automatic int dw(input int i);
    return (i == 0) ? 8 : 32;
  endfunction
  function automatic int dd(input int i);
    return (i == 1) ? 1 : 4;
  endfunction
  function automatic int rw(input int i);
    case (i)
      0: return 8;
      1: return 8;
      2: return 32;
      default: return 16;
    endcase
  endfunction
  function automatic int rd(input int i);
    case (i)
      0: return 1;
      1: return 8;
      2: return 4;
      default: return 2;
    endcase
  endfunction

  // ---------------- directed instances ----------------
  logic        d_rst_n[3];
  logic        d_iv[3], d_ir[3], d_ov[3], d_or[3], d_cin[3], d_sub[3], d_co[3], d_ovf[3];
  logic [31:0] d_a[3], d_b[3], d_sum[3];
  state_t      d_st[3];

  for (genvar g = 0; g < 3; g++) begin : g_dir
    localparam int W = dw(g);
    localparam int D = dd(g);
    logic [W-1:0] s;
    serial_adder #(.WIDTH(W), .DIGIT(D)) u_dut (
      .clk(clk), .rst_n(d_rst_n[g]), .in_valid(d_iv[g]), .in_ready(d_ir[g]),
      .a(d_a[g][W-1:0]), .b(d_b[g][W-1:0]), .cin(d_cin[g]), .sub(d_sub[g]),
      .out_valid(d_ov[g]), .out_ready(d_or[g]), .sum(s), .cout(d_co[g]),
      .ovf(d_ovf[g]), .state_dbg(d_st[g])
    );
    assign d_sum[g] = 32'(s);
  end

  // Issue one operation, scramble operands after accept, count edges to out_valid.
  task automatic drun(input int i, input logic [31:0] a, input logic [31:0] b,
                      input logic ci, input logic sb, output int lat);
    @(negedge clk);
    check("ready_before_issue", d_ir[i], 1'b1);
    d_a[i] = a; d_b[i] = b; d_cin[i] = ci; d_sub[i] = sb; d_iv[i] = 1'b1;
    @(negedge clk);
    d_iv[i] = 1'b0;
    d_a[i] = $urandom; d_b[i] = $urandom; d_cin[i] = 1'($urandom); d_sub[i] = 1'($urandom);
    lat = 0;
    while (!d_ov[i] && lat < 100) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (lat == 1) begin
        d_a[i] = ~a; d_b[i] = ~b;
      end
    end
  endtask

  task automatic dtake(input int i);
    d_or[i] = 1'b1;
    @(negedge clk);
    d_or[i] = 1'b0;
    check("valid_drop_after_take", d_ov[i], 1'b0);
    check("ready_after_take", d_ir[i], 1'b1);
  endtask

  task automatic dres(input int i, input string tag, input logic [31:0] s, input logic co, input logic ov);
    check({tag, "_sum"}, d_sum[i], s);
    check({tag, "_cout"}, d_co[i], co);
    check({tag, "_ovf"}, d_ovf[i], ov);
  endtask

  // ---------------- random regression instances ----------------
  logic [31:0] unused_sink;

  for (genvar g = 0; g < 4; g++) begin : g_rnd
    localparam int W = rw(g);
    localparam int D = rd(g);
    logic         iv, ir, ov, ordy, ci, sb, co, of;
    logic [W-1:0] a, b, s;
    state_t       st;
    logic [33:0]  exp_q[$];
    int           sent, got;

    serial_adder #(.WIDTH(W), .DIGIT(D)) u_dut (
      .clk(clk), .rst_n(rst_n), .in_valid(iv), .in_ready(ir), .a(a), .b(b),
      .cin(ci), .sub(sb), .out_valid(ov), .out_ready(ordy), .sum(s), .cout(co),
      .ovf(of), .state_dbg(st)
    );

    initial begin : producer
      int idle, guard;
      iv = 1'b0; a = '0; b = '0; ci = 1'b0; sb = 1'b0; sent = 0;
      @(posedge rst_n);
      repeat (NTX) begin
        idle = $urandom_range(0, 3);
        repeat (idle) @(negedge clk);
        @(negedge clk);
        a = W'($urandom); b = W'($urandom);
        ci = 1'($urandom_range(0, 1)); sb = 1'($urandom_range(0, 1));
        iv = 1'b1;
        guard = 0;
        while (!ir && guard < 200) begin
          @(negedge clk);
          guard++;
        end
        if (guard >= 200) check($sformatf("rnd%0d_accept_timeout", g), 64'(guard), 64'd0);
        exp_q.push_back(ref_model(W, 32'(a), 32'(b), ci, sb));
        sent++;
        @(negedge clk);
        iv = 1'b0;
        a = W'($urandom); b = W'($urandom);
        ci = 1'($urandom_range(0, 1)); sb = 1'($urandom_range(0, 1));
      end
    end

    initial begin : consumer
      int budget;
      logic [33:0] e;
      ordy = 1'b0; got = 0; budget = 0;
      @(posedge rst_n);
      while (got < NTX && budget < BUDGET) begin
        @(negedge clk);
        budget++;
        ordy = ($urandom_range(0, 1) == 1);
        if (ov && ordy) begin
          if (exp_q.size() == 0) begin
            check($sformatf("rnd%0d_unexpected_result", g), 64'd1, 64'd0);
          end else begin
            e = exp_q.pop_front();
            check($sformatf("rnd%0d_sum", g), 64'(s), 64'(e[31:0]));
            check($sformatf("rnd%0d_cout", g), 64'(co), 64'(e[32]));
            check($sformatf("rnd%0d_ovf", g), 64'(of), 64'(e[33]));
            check($sformatf("rnd%0d_state_done", g), 64'(st), 64'(DONE));
          end
          got++;
        end
      end
      ordy = 1'b0;
      check($sformatf("rnd%0d_results", g), 64'(got), 64'(NTX));
      check($sformatf("rnd%0d_sent", g), 64'(sent), 64'(NTX));
      check($sformatf("rnd%0d_queue_left", g), 64'(exp_q.size()), 64'd0);
      rnd_done_cnt++;
    end
  end

  // ---------------- directed sequence and report ----------------
  initial begin : main
    int lat, w;
    for (int i = 0; i < 3; i++) begin
      d_rst_n[i] = 1'b0; d_iv[i] = 1'b0; d_or[i] = 1'b0;
      d_a[i] = '0; d_b[i] = '0; d_cin[i] = 1'b0; d_sub[i] = 1'b0;
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) d_rst_n[i] = 1'b1;
    @(negedge clk);
    check("reset_ready", d_ir[0], 1'b1);
    check("reset_valid", d_ov[0], 1'b0);
    check("reset_state", d_st[0], IDLE);
    dres(0, "reset", 32'h0, 1'b0, 1'b0);

    // 8-bit, 4-bit digits: signed overflow case and latency of 2
    drun(0, 32'h3C, 32'h55, 1'b0, 1'b0, lat);
    check("lat_8x4", 64'(lat), 64'd2);
    dres(0, "add_3c_55", 32'h91, 1'b0, 1'b1);

    // backpressure: results and flags frozen, in_valid during DONE ignored
    d_iv[0] = 1'b1; d_a[0] = 32'h01; d_b[0] = 32'h01;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("bp_valid", d_ov[0], 1'b1);
      check("bp_ready", d_ir[0], 1'b0);
      dres(0, "bp_hold", 32'h91, 1'b0, 1'b1);
    end
    d_iv[0] = 1'b0;
    dtake(0);

    drun(0, 32'h10, 32'h20, 1'b1, 1'b1, lat);
    dres(0, "sub_10_20", 32'hF0, 1'b0, 1'b0);
    dtake(0);
    drun(0, 32'hFF, 32'h01, 1'b1, 1'b0, lat);
    dres(0, "add_ff_01_c", 32'h01, 1'b1, 1'b0);
    dtake(0);

    // 32-bit, 1-bit digits
    drun(1, 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, lat);
    check("lat_32x1", 64'(lat), 64'd32);
    dres(1, "add_wrap32", 32'h0, 1'b1, 1'b0);
    dtake(1);

    // 32-bit, 4-bit digits: reset on the 2nd RUN cycle discards the operation
    drun(2, 32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, lat);
    check("lat_32x4", 64'(lat), 64'd8);
    dres(2, "pre_reset", 32'h2345_6789, 1'b0, 1'b0);
    dtake(2);
    @(negedge clk);
    d_a[2] = 32'h7FFF_FFFF; d_b[2] = 32'h1; d_cin[2] = 1'b0; d_sub[2] = 1'b0; d_iv[2] = 1'b1;
    @(negedge clk);
    d_iv[2] = 1'b0;
    @(negedge clk);
    d_rst_n[2] = 1'b0;
    @(negedge clk);
    check("mid_reset_valid", d_ov[2], 1'b0);
    check("mid_reset_ready", d_ir[2], 1'b1);
    dres(2, "mid_reset", 32'h0, 1'b0, 1'b0);
    d_rst_n[2] = 1'b1;
    drun(2, 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, lat);
    check("lat_after_reset", 64'(lat), 64'd8);
    dres(2, "post_reset", 32'h8000_0000, 1'b0, 1'b1);
    dtake(2);

    w = 0;
    while (rnd_done_cnt < 4 && w < BUDGET + 10000) begin
      @(negedge clk);
      w++;
    end
    check("rnd_blocks_done", 64'(rnd_done_cnt), 64'd4);
    unused_sink = d_sum[0];
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
